// File: rtl/debug_fmt_pkg.sv
// Shared types, line layout constants and the nibble-to-ASCII helper for the
// debug status line formatter.
package debug_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MSG_LEN       = 21;
    localparam int MSG_LEN_CKSUM = 25;

    // Byte positions of the variable fields within "STAT: C F:HHHH E:EE".
    localparam logic [4:0] IDX_C  = 5'd6;
    localparam logic [4:0] IDX_H3 = 5'd10;
    localparam logic [4:0] IDX_E1 = 5'd17;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

endpackage

// File: rtl/debug_period_timer.sv
// Free-running down-counter that pulses tick for one cycle every PERIOD_CYCLES.
module debug_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [31:0] RELOAD = 32'(PERIOD_CYCLES - 1);

    logic [31:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RELOAD;
        end else if (count == 32'd0) begin
            count <= RELOAD;
        end else begin
            count <= count - 32'd1;
        end
    end

    assign tick = (count == 32'd0);

endmodule

// File: rtl/debug_status_formatter.sv
// Snapshots status inputs on a periodic tick or force_send and streams a fixed ASCII
// status line over a valid/ready byte interface. Define DEBUG_FMT_CHECKSUM_EN to append " *HH".
module debug_status_formatter
    import debug_fmt_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        config_finished,
    input  logic [15:0] frame_count,
    input  logic [7:0]  error_flags,
    input  logic        force_send,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        msg_busy,
    output logic [15:0] msg_count
);

`ifdef DEBUG_FMT_CHECKSUM_EN
    localparam int LINE_LEN = MSG_LEN_CKSUM;
`else
    localparam int LINE_LEN = MSG_LEN;
`endif
    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

    state_t      state;
    logic        pending;
    logic [4:0]  idx;
    logic        snap_cfg;
    logic [15:0] snap_frame;
    logic [7:0]  snap_err;
    logic [7:0]  char_sel;
    logic        tick;
    logic        trigger;
    logic        accept;
`ifdef DEBUG_FMT_CHECKSUM_EN
    logic [7:0]  cksum;
`endif

    debug_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // A tick coinciding with force_send is one trigger.
    assign trigger = tick | force_send;
    assign accept  = (state == EMIT) & byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= 5'd0;
            msg_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) state <= SNAP;
                end
                SNAP: begin
                    idx     <= 5'd0;
                    pending <= pending | trigger;
                    state   <= EMIT;
                end
                EMIT: begin
                    pending <= pending | trigger;
                    if (byte_ready) begin
                        if (idx == LAST_IDX) state <= DONE;
                        else                 idx   <= idx + 5'd1;
                    end
                end
                DONE: begin
                    msg_count <= msg_count + 16'd1;
                    // A trigger landing in DONE folds into the pending request.
                    if (pending || trigger) begin
                        pending <= 1'b0;
                        state   <= SNAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: snapshot and checksum are pure datapath, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == SNAP) begin
            snap_cfg   <= config_finished;
            snap_frame <= frame_count;
            snap_err   <= error_flags;
        end
    end

`ifdef DEBUG_FMT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (state == SNAP) begin
            cksum <= 8'h00;
        end else if (accept && (idx <= IDX_E1 + 5'd1)) begin
            cksum <= cksum ^ char_sel;
        end
    end
`endif

    // NOTE: char_sel gets a default before the case so no latch is inferred.
    always_comb begin
        char_sel = 8'h20;
        case (idx)
            5'd0:           char_sel = "S";
            5'd1:           char_sel = "T";
            5'd2:           char_sel = "A";
            5'd3:           char_sel = "T";
            5'd4:           char_sel = ":";
            IDX_C:          char_sel = snap_cfg ? "R" : "N";
            5'd8:           char_sel = "F";
            5'd9:           char_sel = ":";
            IDX_H3:         char_sel = hex_to_ascii(snap_frame[15:12]);
            IDX_H3 + 5'd1:  char_sel = hex_to_ascii(snap_frame[11:8]);
            IDX_H3 + 5'd2:  char_sel = hex_to_ascii(snap_frame[7:4]);
            IDX_H3 + 5'd3:  char_sel = hex_to_ascii(snap_frame[3:0]);
            5'd15:          char_sel = "E";
            5'd16:          char_sel = ":";
            IDX_E1:         char_sel = hex_to_ascii(snap_err[7:4]);
            IDX_E1 + 5'd1:  char_sel = hex_to_ascii(snap_err[3:0]);
`ifdef DEBUG_FMT_CHECKSUM_EN
            5'd20:          char_sel = "*";
            5'd21:          char_sel = hex_to_ascii(cksum[7:4]);
            5'd22:          char_sel = hex_to_ascii(cksum[3:0]);
            5'd23:          char_sel = 8'h0D;
            5'd24:          char_sel = 8'h0A;
`else
            5'd19:          char_sel = 8'h0D;
            5'd20:          char_sel = 8'h0A;
`endif
            default:        char_sel = 8'h20;
        endcase
    end

    assign byte_valid = (state == EMIT);
    assign byte_data  = byte_valid ? char_sel : 8'h00;
    assign msg_busy   = (state == SNAP) || (state == EMIT);

endmodule

// File: tb/tb_debug_status_formatter.sv
// Randomized bench for debug_status_formatter: a string-level reference model predicts
// every cycle's outputs; directed phases cover latency, stalls, pending, abort and zeros.
module tb_debug_status_formatter;

    localparam int P = 100;
`ifdef DEBUG_FMT_CHECKSUM_EN
    localparam int LINE_LEN = 25;
`else
    localparam int LINE_LEN = 21;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        config_finished;
    logic [15:0] frame_count;
    logic [7:0]  error_flags;
    logic        force_send;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        msg_busy;
    logic [15:0] msg_count;

    int checks = 0;
    int errors = 0;

    // Reference model: message lifecycle flags plus the expected line as a string.
    bit          m_snap, m_emit, m_done, m_pend;
    int          m_pos;
    int          m_cyc;
    bit [15:0]   m_count;
    string       m_line;

    logic [7:0]  rx[$];
    bit          stalled_prev;
    logic [7:0]  prev_data;

    debug_status_formatter #(
        .PERIOD_CYCLES(P)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .config_finished (config_finished),
        .frame_count     (frame_count),
        .error_flags     (error_flags),
        .force_send      (force_send),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .msg_busy        (msg_busy),
        .msg_count       (msg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string expect_line(input bit c, input bit [15:0] f, input bit [7:0] e);
        string s;
        bit [7:0] x;
        s = $sformatf("STAT: %s F:%04h E:%02h", c ? "R" : "N", f, e);
        s = s.toupper();
`ifdef DEBUG_FMT_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < s.len(); i++) x = x ^ s[i];
        s = {s, " *", $sformatf("%02h", x).toupper()};
`endif
        return {s, "\r\n"};
    endfunction

    task automatic model_reset();
        m_snap  = 0;
        m_emit  = 0;
        m_done  = 0;
        m_pend  = 0;
        m_pos   = 0;
        m_count = 16'd0;
        m_cyc   = 0;
    endtask

    // Called at a negedge with this cycle's inputs already driven.
    task automatic step();
        logic [7:0] exp_data;
        bit trig;
        exp_data = m_emit ? m_line[m_pos] : 8'h00;
        check("byte_valid", byte_valid, m_emit);
        check("byte_data", byte_data, exp_data);
        check("msg_busy", msg_busy, m_snap || m_emit);
        check("msg_count", msg_count, m_count);
        if (stalled_prev) check("stall_hold", byte_data, prev_data);
        stalled_prev = byte_valid && !byte_ready && !reset;
        prev_data    = byte_data;
        if (byte_valid && byte_ready && !reset) rx.push_back(byte_data);

        if (reset) begin
            model_reset();
        end else begin
            trig = ((m_cyc % P) == P - 1) || force_send;
            if (m_snap) begin
                m_line = expect_line(config_finished, frame_count, error_flags);
                m_pos  = 0;
                m_snap = 0;
                m_emit = 1;
                if (trig) m_pend = 1;
            end else if (m_emit) begin
                if (trig) m_pend = 1;
                if (byte_ready) begin
                    if (m_pos == m_line.len() - 1) begin
                        m_emit = 0;
                        m_done = 1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (m_done) begin
                m_count++;
                m_done = 0;
                if (m_pend || trig) begin
                    m_pend = 0;
                    m_snap = 1;
                end
            end else if (trig) begin
                m_snap = 1;
            end
            m_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input int off, input string exp);
        check({tag, "_len"}, 32'(rx.size() >= off + exp.len()), 32'd1);
        for (int i = 0; i < exp.len(); i++)
            if (off + i < rx.size()) check(tag, rx[off + i], exp[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_snap || m_emit || m_done || m_pend) && n < 300) begin
            step();
            n++;
        end
        check("wait_idle_bound", 32'(n < 300), 32'd1);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(m_emit && m_pos == p) && n < 100) begin
            step();
            n++;
        end
        check("wait_pos_bound", 32'(n < 100), 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        force_send      = 1'b0;
        byte_ready      = 1'b0;
        config_finished = 1'b0;
        frame_count     = 16'h0000;
        error_flags     = 8'h00;
        stalled_prev    = 0;
        prev_data       = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        step();
        reset = 1'b0;
        check("rst_valid", byte_valid, 1'b0);
        check("rst_count", msg_count, 16'd0);
        step();
        step();

        // Basic line with immediate request and an always-ready sink.
        config_finished = 1'b1;
        frame_count     = 16'h1A2F;
        error_flags     = 8'h05;
        byte_ready      = 1'b1;
        rx.delete();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        step();
        check("first_valid", byte_valid, 1'b1);
        check("first_byte", byte_data, 8'h53);
        repeat (LINE_LEN + 3) step();
        check("count_after_first", msg_count, 16'd1);
        check_rx("line_a", 0, expect_line(1'b1, 16'h1A2F, 8'h05));
`ifndef DEBUG_FMT_CHECKSUM_EN
        check_rx("line_a_lit", 0, "STAT: R F:1A2F E:05\r\n");
`endif

        // Random back-pressure, frame_count changes mid-line; later tick sends FFFF.
        rx.delete();
        force_send = 1'b1;
        byte_ready = 1'($urandom_range(0, 1));
        step();
        force_send = 1'b0;
        for (int i = 0; i < 180; i++) begin
            byte_ready = 1'($urandom_range(0, 1));
            if (i == 6) frame_count = 16'hFFFF;
            step();
        end
        check_rx("line_b", 0, "STAT: R F:1A2F E:05");
        check_rx("line_b_next", LINE_LEN, "STAT: R F:FFFF E:05");

        // Request during byte 5 queues a second line straight after DONE.
        byte_ready = 1'b1;
        wait_idle();
        rx.delete();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        wait_pos(5);
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        repeat (3 * P) step();
        check_rx("pending_line", LINE_LEN, expect_line(1'b1, 16'hFFFF, 8'h05));

        // Reset during byte 10 aborts the line without counting it.
        wait_idle();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        wait_pos(10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", byte_valid, 1'b0);
        check("abort_count", msg_count, 16'd0);
        rx.delete();
        step();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        repeat (LINE_LEN + 4) step();
        check_rx("restart_line", 0, expect_line(1'b1, 16'hFFFF, 8'h05));

        // All-zero inputs (checksum content when the feature is built in).
        wait_idle();
        config_finished = 1'b0;
        frame_count     = 16'h0000;
        error_flags     = 8'h00;
        rx.delete();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        repeat (LINE_LEN + 4) step();
        check_rx("zero_line", 0, expect_line(1'b0, 16'h0000, 8'h00));
        check_rx("zero_prefix", 0, "STAT: N F:0000 E:00");

        // Fully random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            force_send = ($urandom_range(0, 29) == 0);
            byte_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) begin
                config_finished = 1'($urandom_range(0, 1));
                frame_count     = 16'($urandom);
                error_flags     = 8'($urandom);
            end
            step();
        end
        reset      = 1'b0;
        force_send = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
